// File: rtl/pll_sup_pkg.sv
// Shared definitions for the HDMI-lite pixel PLL supervisor: state codes,
// the retry counter width and the counter-width helper.
package pll_sup_pkg;

  // State codes are plain constants so legacy tools and waveform scripts
  // can match them by value.
  typedef logic [2:0] state_t;

  localparam state_t RESET_PLL = 3'd0;
  localparam state_t WAIT_LOCK = 3'd1;
  localparam state_t STABILIZE = 3'd2;
  localparam state_t RUN       = 3'd3;
  localparam state_t FAIL      = 3'd4;

  localparam int RETRY_W = 8;

  // Width of a counter that must hold values up to the largest of three limits.
  // The extra bit keeps the terminal compare free of wrap concerns.
  function automatic int cnt_width(input int unsigned a, input int unsigned b,
                                   input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_hdmi_lite_supervisor_sync_bit.sv
// Multi-stage synchronizer for a single asynchronous level; resets to 0.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge.
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_hdmi_lite_supervisor.sv
// Reset and lock supervisor for the HDMI-lite pixel PLL (refclk domain).
// Sequences the PLL reset, qualifies the synchronized lock flag, retries on
// lock timeout and releases the video-domain reset once lock is stable.
// Optional build macro PLLSUP_FAIL_LATCH_EN: after MAX_RETRIES timeouts the
// supervisor parks in FAIL (PLL held in reset) until rst_n. The MAX_RETRIES
// parameter only exists when that macro is defined.
module pll_hdmi_lite_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1120000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES   = 2
`ifdef PLLSUP_FAIL_LATCH_EN
  , parameter int unsigned MAX_RETRIES = 8
`endif
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               clr_status,
  output logic               pll_rst,
  output logic               video_rst_n,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               fail
);

  localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef PLLSUP_FAIL_LATCH_EN
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, video_rst_n_q, ready_q, lock_lost_q;
  logic               pll_rst_d, video_rst_n_d, ready_d, lock_lost_d;
  logic               lock_s, sync_rst_n, timeout, lost_ev, clr_retry;

  // The lock flag is meaningless while the PLL is held in reset, so the
  // synchronizer is flushed then; qualification always starts from fresh lock.
  assign sync_rst_n = rst_n & ~pll_rst_q;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (refclk),
    .rst_n (sync_rst_n),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

`ifdef PLLSUP_FAIL_LATCH_EN
  assign clr_retry = clr_status && (state_q != FAIL);
`else
  assign clr_retry = clr_status;
`endif

  // Sequencing FSM with one shared cycle counter, cleared on every state entry.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    lost_ev = 1'b0;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          timeout = 1'b1;
          state_d = RESET_PLL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          lost_ev = 1'b1;
          state_d = RESET_PLL;
          cnt_d   = '0;
        end
      end
`ifdef PLLSUP_FAIL_LATCH_EN
      FAIL: state_d = FAIL;
`endif
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase
`ifdef PLLSUP_FAIL_LATCH_EN
    if (timeout && (retry_q == RETRY_LAST)) state_d = FAIL;
`endif
  end

  // Status and output next-state: events beat a coincident clear.
  always_comb begin
    retry_d = retry_q;
    if (clr_retry) retry_d = '0;
    if (timeout) begin
      if (clr_retry)             retry_d = RETRY_W'(1);
      else if (retry_q != '1)    retry_d = retry_q + 1'b1;
    end
`ifdef PLLSUP_FAIL_LATCH_EN
    if (timeout && (retry_q == RETRY_LAST)) retry_d = RETRY_W'(MAX_RETRIES);
`endif
    lock_lost_d   = lost_ev | (lock_lost_q & ~clr_status);
    pll_rst_d     = (state_d == RESET_PLL) || (state_d == FAIL);
    ready_d       = (state_d == RUN);
    video_rst_n_d = (state_d == RUN);
  end

  // State, counter and registered outputs.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q       <= RESET_PLL;
      cnt_q         <= '0;
      retry_q       <= '0;
      pll_rst_q     <= 1'b1;
      video_rst_n_q <= 1'b0;
      ready_q       <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      pll_rst_q     <= pll_rst_d;
      video_rst_n_q <= video_rst_n_d;
      ready_q       <= ready_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

`ifdef PLLSUP_FAIL_LATCH_EN
  logic fail_q;

  // Sticky failure flag, mirrors the FAIL state.
  always_ff @(posedge refclk) begin
    if (!rst_n) fail_q <= 1'b0;
    else        fail_q <= (state_d == FAIL);
  end

  assign fail = fail_q;
`else
  assign fail = 1'b0;
`endif

  assign pll_rst     = pll_rst_q;
  assign video_rst_n = video_rst_n_q;
  assign ready       = ready_q;
  assign lock_lost   = lock_lost_q;
  assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_pll_hdmi_lite_supervisor.sv
// Scoreboard bench for pll_hdmi_lite_supervisor: every stimulus cycle steps a
// phase/countdown reference model and queues the expected outputs; a monitor
// on the falling edge pops and compares. Directed latency checks use constants.
module tb_pll_hdmi_lite_supervisor;

  localparam int RST  = 4;
  localparam int TMO  = 32;
  localparam int STB  = 8;
  localparam int SYN  = 2;
  localparam int MAXR = 3;
`ifdef PLLSUP_FAIL_LATCH_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif
  localparam int CLR_AT = FEAT ? 1 : 2;

  logic       refclk = 1'b0;
  logic       rst_n, pll_locked, clr_status;
  logic       pll_rst, video_rst_n, ready, lock_lost, fail;
  logic [7:0] retry_cnt;

  pll_hdmi_lite_supervisor #(
    .RST_CYCLES   (RST),
    .LOCK_TIMEOUT (TMO),
    .STABLE_CYCLES(STB),
    .SYNC_STAGES  (SYN)
`ifdef PLLSUP_FAIL_LATCH_EN
    , .MAX_RETRIES(MAXR)
`endif
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .clr_status (clr_status),
    .pll_rst    (pll_rst),
    .video_rst_n(video_rst_n),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retry_cnt  (retry_cnt),
    .fail       (fail)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic       pll_rst;
    logic       vrst_n;
    logic       ready;
    logic       lost;
    logic       fail;
    logic [7:0] retry;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PLL reset countdown, lock-wait countdown, count of
  // qualified lock cycles, and a sync pipe of lock samples.
  typedef enum {HOLD, SEEK, QUAL, UP, DEAD} phase_e;
  phase_e         ph = HOLD;
  int             hold_left = RST;
  int             seek_left = 0;
  int             qual = 0;
  int             m_retry = 0;
  bit             m_lost = 1'b0;
  bit             m_pll_rst = 1'b1;
  logic [SYN-1:0] pipe = '0;

  task automatic model_step(input bit r, input bit l, input bit c);
    bit   ls, to, lost_ev, clr_ok;
    exp_t e;
    if (!r) begin
      ph = HOLD; hold_left = RST; seek_left = 0; qual = 0;
      m_retry = 0; m_lost = 1'b0; pipe = '0;
    end else begin
      ls      = pipe[SYN-1];
      pipe    = m_pll_rst ? '0 : {pipe[SYN-2:0], l};
      to      = 1'b0;
      lost_ev = 1'b0;
      clr_ok  = c && (ph != DEAD);
      case (ph)
        HOLD: begin
          hold_left--;
          if (hold_left == 0) begin ph = SEEK; seek_left = TMO; end
        end
        SEEK: begin
          if (ls) begin ph = QUAL; qual = 0; end
          else begin
            seek_left--;
            if (seek_left == 0) begin to = 1'b1; ph = HOLD; hold_left = RST; end
          end
        end
        QUAL: begin
          if (!ls) begin ph = SEEK; seek_left = TMO; end
          else begin
            qual++;
            if (qual == STB) ph = UP;
          end
        end
        UP: if (!ls) begin lost_ev = 1'b1; ph = HOLD; hold_left = RST; end
        default: ;
      endcase
      if (to) begin
        if (FEAT && m_retry == MAXR - 1) begin m_retry = MAXR; ph = DEAD; end
        else if (clr_ok) m_retry = 1;
        else if (m_retry < 255) m_retry++;
      end else if (clr_ok) m_retry = 0;
      if (lost_ev) m_lost = 1'b1;
      else if (c) m_lost = 1'b0;
    end
    m_pll_rst = (ph == HOLD) || (ph == DEAD);
    e.pll_rst = m_pll_rst;
    e.vrst_n  = (ph == UP);
    e.ready   = (ph == UP);
    e.lost    = m_lost;
    e.fail    = (ph == DEAD);
    e.retry   = 8'(m_retry);
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge refclk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_pll_rst", pll_rst, e.pll_rst);
      check("sb_video_rst_n", video_rst_n, e.vrst_n);
      check("sb_ready", ready, e.ready);
      check("sb_lock_lost", lock_lost, e.lost);
      check("sb_fail", fail, e.fail);
      check("sb_retry_cnt", retry_cnt, e.retry);
    end
  end

  task automatic cycle(input bit r, input bit l, input bit c);
    rst_n = r; pll_locked = l; clr_status = c;
    @(posedge refclk);
    model_step(r, l, c);
    @(negedge refclk);
  endtask

  // Release reset with lock present; check pulse length and ready latency.
  task automatic relock_sequence(input string tag);
    int n;
    n = 0;
    while (pll_rst !== 1'b0 && n < 20) begin cycle(1, 1, 0); n++; end
    check({tag, "_pll_rst_len"}, n, RST);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin cycle(1, 1, 0); n++; end
    check({tag, "_ready_latency"}, n, SYN + STB + 1);
    check({tag, "_video_rst_n"}, video_rst_n, 1);
  endtask

  task automatic steer_to_qual(input int target);
    int n;
    n = 0;
    while (!(ph == QUAL && qual == target) && n < 200) begin cycle(1, 1, 0); n++; end
    check("steer_qual_reached", (n < 200), 1);
  endtask

  initial begin
    int  n;
    bit  lv, rv, cv;
    int  len;
    rst_n = 1'b0; pll_locked = 1'b0; clr_status = 1'b0;

    // 1: power-up with lock present throughout
    repeat (3) cycle(0, 1, 0);
    check("t1_reset_pll_rst", pll_rst, 1);
    relock_sequence("t1");
    check("t1_retry", retry_cnt, 0);

    // 2: no lock, retries every RST+TMO cycles
    cycle(0, 0, 0);
    n = 0;
    while (retry_cnt !== 8'd1 && n < 100) begin cycle(1, 0, 0); n++; end
    check("t2_first_timeout", n, RST + TMO);
    n = 0;
    while (retry_cnt !== 8'd2 && n < 100) begin cycle(1, 0, 0); n++; end
    check("t2_retry_period", n, RST + TMO);
`ifdef PLLSUP_FAIL_LATCH_EN
    repeat (2 * (RST + TMO)) cycle(1, 0, 0);
    check("t2_fail", fail, 1);
    check("t2_retry_at_fail", retry_cnt, MAXR);
    check("t2_pll_rst_held", pll_rst, 1);
    cycle(1, 0, 1);
    check("t2_clr_ignored_in_fail", retry_cnt, MAXR);
`else
    repeat (256 * (RST + TMO)) cycle(1, 0, 0);
    check("t2_retry_saturated", retry_cnt, 255);
    check("t2_fail_tied", fail, 0);
`endif

    // 3: lock glitch during qualification restarts it
    cycle(0, 1, 0);
    steer_to_qual(5);
    repeat (3) cycle(1, 0, 0);
    n = 0;
    while (ready !== 1'b1 && n < 60) begin cycle(1, 1, 0); n++; end
    check("t3_requalify_latency", n, SYN + STB + 1);
    check("t3_retry_unchanged", retry_cnt, 0);

    // 4: lock loss in RUN
    n = 0;
    while (ready !== 1'b0 && n < 10) begin cycle(1, 0, 0); n++; end
    check("t4_drop_latency", n, SYN + 1);
    check("t4_video_rst_n", video_rst_n, 0);
    check("t4_lock_lost", lock_lost, 1);
    relock_sequence("t4");
    check("t4_lock_lost_sticky", lock_lost, 1);
    check("t4_retry_unchanged", retry_cnt, 0);

    // 5: clear colliding with a timeout increment, then clear alone
    n = 0;
    while (!(m_retry == CLR_AT && ph == SEEK && seek_left == 1) && n < 400) begin
      cycle(1, 0, 0); n++;
    end
    check("t5_reached", (n < 400), 1);
    check("t5_lost_before", lock_lost, 1);
    cycle(1, 0, 1);
    check("t5_clr_with_timeout", retry_cnt, 1);
    cycle(1, 0, 1);
    check("t5_clr_alone_retry", retry_cnt, 0);
    check("t5_clr_alone_lost", lock_lost, 0);

    // 6: reset mid-qualification and after repeated timeouts
    cycle(0, 1, 0);
    steer_to_qual(3);
    cycle(0, 1, 0);
    check("t6a_pll_rst", pll_rst, 1);
    check("t6a_ready", ready, 0);
    check("t6a_video_rst_n", video_rst_n, 0);
    relock_sequence("t6a");
    repeat (3 * (RST + TMO) + 10) cycle(1, 0, 0);
    cycle(0, 0, 0);
    check("t6b_retry", retry_cnt, 0);
    check("t6b_fail", fail, 0);
    check("t6b_pll_rst", pll_rst, 1);
    relock_sequence("t6b");

    // 7: random lock runs and glitches, occasional clears and resets
    for (int i = 0; i < 3000; ) begin
      lv  = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 40);
      for (int j = 0; j < len; j++) begin
        rv = ($urandom_range(0, 299) != 0);
        cv = ($urandom_range(0, 15) == 0);
        cycle(rv, lv, cv);
        i++;
      end
    end

    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
